// File: rtl/process_muldiv_if.sv
// Handshake and data bundle for the process_muldiv execution unit.
//   start, op, a_data, b_data, psw_in : request side (driven by the master)
//   busy, done, ans_a, ans_b, psw_out : response side (driven by the unit)
// modport master: the requester (CPU process stage or testbench)
// modport slave : the multiply/divide unit itself
interface process_muldiv_if #(
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              op;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [7:0]        psw_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] ans_a;
    logic [DATA_W-1:0] ans_b;
    logic [7:0]        psw_out;

    modport master (
        output start, op, a_data, b_data, psw_in,
        input  busy, done, ans_a, ans_b, psw_out
    );

    modport slave (
        input  start, op, a_data, b_data, psw_in,
        output busy, done, ans_a, ans_b, psw_out
    );
endinterface

// File: rtl/process_muldiv.sv
// Iterative MUL AB / DIV AB unit for the extended ALU opcode slot.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : process_muldiv_if.slave
//          start/op/a_data/b_data/psw_in in, busy/done/ans_a/ans_b/psw_out out
// MUL is shift-add (one multiplier bit per cycle), DIV is restoring division (one
// quotient bit per cycle); both take DATA_W iteration cycles followed by a one-cycle
// DONE state. CY is cleared, OV and P recomputed, other PSW bits pass through.
module process_muldiv #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CY_BIT = 7,
    parameter int unsigned OV_BIT = 2,
    parameter int unsigned P_BIT  = 0
) (
    input logic clk,
    input logic rst,
    process_muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q, state_d;
    // acc: product high half (MUL) or partial remainder (DIV)
    // mq : multiplier shifting out / product low half (MUL), dividend / quotient (DIV)
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mq_q, mq_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [7:0]        psw_q, psw_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] ans_a_q, ans_a_d;
    logic [DATA_W-1:0] ans_b_q, ans_b_d;
    logic [7:0]        psw_out_q, psw_out_d;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_acc_nx, mul_mq_nx;
    logic [DATA_W:0]   div_sh, div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] div_rem_nx, div_mq_nx;
    logic              last_iter;

    function automatic logic [7:0] upd_psw(input logic [7:0] p, input logic ov,
                                           input logic [DATA_W-1:0] a);
        logic [7:0] r;
        r         = p;
        r[CY_BIT] = 1'b0;
        r[OV_BIT] = ov;
        r[P_BIT]  = ^a;
        return r;
    endfunction

    always_comb begin
        // Shift-add step: add B when the current multiplier LSB is set, then shift
        // the {acc, mq} pair right so the carry lands in acc's MSB.
        mul_sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        mul_acc_nx = mul_sum[DATA_W:1];
        mul_mq_nx  = {mul_sum[0], mq_q[DATA_W-1:1]};

        // Restoring step: bring in the next dividend bit, subtract if it fits.
        div_sh     = {acc_q, mq_q[DATA_W-1]};
        div_diff   = div_sh - {1'b0, b_q};
        div_ge     = (div_sh >= {1'b0, b_q});
        div_rem_nx = div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
        div_mq_nx  = {mq_q[DATA_W-2:0], div_ge};

        last_iter  = (cnt_q == CntW'(DATA_W - 1));
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        b_d       = b_q;
        psw_d     = psw_q;
        cnt_d     = cnt_q;
        ans_a_d   = ans_a_q;
        ans_b_d   = ans_b_q;
        psw_out_d = psw_out_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    b_d   = bus.b_data;
                    psw_d = bus.psw_in;
                    acc_d = '0;
                    mq_d  = bus.a_data;
                    cnt_d = '0;
                    if (!bus.op) begin
                        state_d = StMul;
                    end else if (bus.b_data != '0) begin
                        state_d = StDiv;
                    end else begin
                        // Divide by zero resolves on the accept edge.
                        state_d   = StDone;
                        ans_a_d   = '1;
                        ans_b_d   = bus.a_data;
                        psw_out_d = upd_psw(bus.psw_in, 1'b1, '1);
                    end
                end
            end
            StMul: begin
                acc_d = mul_acc_nx;
                mq_d  = mul_mq_nx;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d   = StDone;
                    ans_a_d   = mul_mq_nx;
                    ans_b_d   = mul_acc_nx;
                    psw_out_d = upd_psw(psw_q, |mul_acc_nx, mul_mq_nx);
                end
            end
            StDiv: begin
                acc_d = div_rem_nx;
                mq_d  = div_mq_nx;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d   = StDone;
                    ans_a_d   = div_mq_nx;
                    ans_b_d   = div_rem_nx;
                    psw_out_d = upd_psw(psw_q, 1'b0, div_mq_nx);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mq_q      <= '0;
            b_q       <= '0;
            psw_q     <= '0;
            cnt_q     <= '0;
            ans_a_q   <= '0;
            ans_b_q   <= '0;
            psw_out_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            b_q       <= b_d;
            psw_q     <= psw_d;
            cnt_q     <= cnt_d;
            ans_a_q   <= ans_a_d;
            ans_b_q   <= ans_b_d;
            psw_out_q <= psw_out_d;
        end
    end

    assign bus.busy    = (state_q == StMul) || (state_q == StDiv);
    assign bus.done    = (state_q == StDone);
    assign bus.ans_a   = ans_a_q;
    assign bus.ans_b   = ans_b_q;
    assign bus.psw_out = psw_out_q;
endmodule

// File: tb/tb_process_muldiv.sv
module tb_process_muldiv;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    process_muldiv_if #(.DATA_W(8))  m8 ();
    process_muldiv_if #(.DATA_W(16)) m16 ();

    process_muldiv #(.DATA_W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (m8)
    );

    process_muldiv #(.DATA_W(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (m16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the last run8 call.
    int done_cyc, busy_n, busy_first, busy_last, changes;

    // Cycle 0 = cycle whose closing edge accepts start. Samples are taken at the
    // falling edge of each following cycle. If now=1 the start is driven in the
    // current cycle (used for back-to-back from a DONE cycle).
    task automatic run8(input bit now, input logic op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] psw, input int pulse_cyc);
        logic [7:0] held;
        if (!now) @(negedge clk);
        held       = m8.ans_a;
        m8.start   = 1'b1;
        m8.op      = op;
        m8.a_data  = a;
        m8.b_data  = b;
        m8.psw_in  = psw;
        done_cyc   = -1;
        busy_n     = 0;
        busy_first = -1;
        busy_last  = -1;
        changes    = 0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                m8.start  = 1'b0;
                m8.op     = ~op;
                m8.a_data = ~a;
                m8.b_data = ~b;
                m8.psw_in = ~psw;
            end
            if (c == pulse_cyc) begin
                m8.start  = 1'b1;
                m8.op     = 1'b1;
                m8.a_data = 8'h55;
                m8.b_data = 8'h03;
            end
            if (c == pulse_cyc + 1) m8.start = 1'b0;
            if (m8.busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                if (m8.ans_a !== held) changes++;
            end
            if (m8.done) done_cyc = c;
        end
    endtask

    task automatic test_reset;
        total++; if (m8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", m8.busy); end
        total++; if (m8.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", m8.done); end
        total++; if (m8.ans_a !== 8'h00 || m8.ans_b !== 8'h00) begin
            bad++; $display("FAIL reset_ans got=%h/%h want=00/00", m8.ans_a, m8.ans_b);
        end
        total++; if (m8.psw_out !== 8'h00) begin bad++; $display("FAIL reset_psw got=%h want=00", m8.psw_out); end
    endtask

    task automatic test_mul_overflow;
        run8(1'b0, 1'b0, 8'h50, 8'hA0, 8'hFF, -5);
        total++; if (done_cyc !== 9) begin bad++; $display("FAIL mul_done_cycle got=%0d want=9", done_cyc); end
        total++; if (busy_n !== 8 || busy_first !== 1 || busy_last !== 8) begin
            bad++; $display("FAIL mul_busy_window got=%0d cycles %0d..%0d want=8 cycles 1..8",
                            busy_n, busy_first, busy_last);
        end
        total++; if (m8.ans_a !== 8'h00) begin bad++; $display("FAIL mul_ov_ans_a got=%h want=00", m8.ans_a); end
        total++; if (m8.ans_b !== 8'h32) begin bad++; $display("FAIL mul_ov_ans_b got=%h want=32", m8.ans_b); end
        total++; if (m8.psw_out !== 8'h7E) begin bad++; $display("FAIL mul_ov_psw got=%h want=7e", m8.psw_out); end
        @(negedge clk);
        total++; if (m8.done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%0b want=0", m8.done); end
    endtask

    task automatic test_mul_small;
        run8(1'b0, 1'b0, 8'h0C, 8'h0B, 8'h00, -5);
        total++; if (done_cyc !== 9) begin bad++; $display("FAIL mul2_done_cycle got=%0d want=9", done_cyc); end
        total++; if (changes !== 0) begin bad++; $display("FAIL mul2_hold_while_busy got=%0d want=0", changes); end
        total++; if (m8.ans_a !== 8'h84 || m8.ans_b !== 8'h00) begin
            bad++; $display("FAIL mul2_ans got=%h/%h want=84/00", m8.ans_a, m8.ans_b);
        end
        total++; if (m8.psw_out !== 8'h00) begin bad++; $display("FAIL mul2_psw got=%h want=00", m8.psw_out); end
    endtask

    task automatic test_div;
        run8(1'b0, 1'b1, 8'hFB, 8'h12, 8'h80, -5);
        total++; if (done_cyc !== 9) begin bad++; $display("FAIL div_done_cycle got=%0d want=9", done_cyc); end
        total++; if (m8.ans_a !== 8'h0D || m8.ans_b !== 8'h11) begin
            bad++; $display("FAIL div_ans got=%h/%h want=0d/11", m8.ans_a, m8.ans_b);
        end
        total++; if (m8.psw_out !== 8'h01) begin bad++; $display("FAIL div_psw got=%h want=01", m8.psw_out); end
    endtask

    task automatic test_div_zero;
        run8(1'b0, 1'b1, 8'h37, 8'h00, 8'h00, -5);
        total++; if (done_cyc !== 1) begin bad++; $display("FAIL divz_done_cycle got=%0d want=1", done_cyc); end
        total++; if (busy_n !== 0) begin bad++; $display("FAIL divz_busy got=%0d cycles want=0", busy_n); end
        total++; if (m8.ans_a !== 8'hFF || m8.ans_b !== 8'h37) begin
            bad++; $display("FAIL divz_ans got=%h/%h want=ff/37", m8.ans_a, m8.ans_b);
        end
        total++; if (m8.psw_out !== 8'h04) begin bad++; $display("FAIL divz_psw got=%h want=04", m8.psw_out); end
    endtask

    task automatic test_ignored_start;
        run8(1'b0, 1'b0, 8'h0C, 8'h0B, 8'h00, 4);
        total++; if (done_cyc !== 9) begin bad++; $display("FAIL ign_done_cycle got=%0d want=9", done_cyc); end
        total++; if (m8.ans_a !== 8'h84 || m8.ans_b !== 8'h00) begin
            bad++; $display("FAIL ign_ans got=%h/%h want=84/00", m8.ans_a, m8.ans_b);
        end
        @(negedge clk);
        total++; if (m8.busy !== 1'b0 || m8.done !== 1'b0) begin
            bad++; $display("FAIL ign_no_queue got=busy%0b/done%0b want=0/0", m8.busy, m8.done);
        end
    endtask

    task automatic test_back_to_back;
        run8(1'b0, 1'b0, 8'h50, 8'hA0, 8'hFF, -5);
        total++; if (done_cyc !== 9) begin bad++; $display("FAIL b2b_first_done got=%0d want=9", done_cyc); end
        run8(1'b1, 1'b1, 8'hFB, 8'h12, 8'h80, -5);
        total++; if (done_cyc !== 9 || busy_first !== 1) begin
            bad++; $display("FAIL b2b_second_done got=%0d busy_from=%0d want=9 busy_from=1",
                            done_cyc, busy_first);
        end
        total++; if (m8.ans_a !== 8'h0D || m8.ans_b !== 8'h11 || m8.psw_out !== 8'h01) begin
            bad++; $display("FAIL b2b_ans got=%h/%h/%h want=0d/11/01", m8.ans_a, m8.ans_b, m8.psw_out);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        m8.start = 1'b1; m8.op = 1'b1; m8.a_data = 8'hFB; m8.b_data = 8'h12; m8.psw_in = 8'h80;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            m8.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++; if (m8.busy !== 1'b0 || m8.done !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=busy%0b/done%0b want=0/0", m8.busy, m8.done);
        end
        total++; if (m8.ans_a !== 8'h00 || m8.ans_b !== 8'h00 || m8.psw_out !== 8'h00) begin
            bad++; $display("FAIL rstmid_outs got=%h/%h/%h want=00/00/00", m8.ans_a, m8.ans_b, m8.psw_out);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (m8.busy || m8.done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_idle got=%0d active cycles want=0", seen); end
        run8(1'b0, 1'b0, 8'h0C, 8'h0B, 8'h00, -5);
        total++; if (done_cyc !== 9 || m8.ans_a !== 8'h84) begin
            bad++; $display("FAIL rstmid_recover got=done%0d/%h want=done9/84", done_cyc, m8.ans_a);
        end
    endtask

    task automatic test_w16;
        int dc;
        @(negedge clk);
        m16.start = 1'b1; m16.op = 1'b0; m16.a_data = 16'hFFFF; m16.b_data = 16'hFFFF;
        m16.psw_in = 8'h00;
        dc = -1;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            @(negedge clk);
            m16.start = 1'b0;
            m16.a_data = 16'h1234;
            if (m16.done) dc = c;
        end
        total++; if (dc !== 17) begin bad++; $display("FAIL w16_done_cycle got=%0d want=17", dc); end
        total++; if (m16.ans_a !== 16'h0001 || m16.ans_b !== 16'hFFFE) begin
            bad++; $display("FAIL w16_ans got=%h/%h want=0001/fffe", m16.ans_a, m16.ans_b);
        end
        total++; if (m16.psw_out !== 8'h05) begin bad++; $display("FAIL w16_psw got=%h want=05", m16.psw_out); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        m8.start = 1'b0;  m8.op = 1'b0;  m8.a_data = '0;  m8.b_data = '0;  m8.psw_in = '0;
        m16.start = 1'b0; m16.op = 1'b0; m16.a_data = '0; m16.b_data = '0; m16.psw_in = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_mul_overflow();
        test_mul_small();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/process_muldiv.md
Name: process_muldiv

Overview:
- Multi-cycle MUL AB / DIV AB execution unit for the CPU process stage.
- Handles the extended opcode slot (alu_op 4'hf) that the combinational ALU path cannot serve.
- Parametrised in datapath width; computes iteratively with a start/busy/done handshake.
- Updates CY, OV and P in a PSW image; all other PSW bits pass through.

Parameters:
- DATA_W, 8, operand/result width in bits (>=4).
- CY_BIT, 7, PSW index of the carry flag.
- OV_BIT, 2, PSW index of the overflow flag.
- P_BIT, 0, PSW index of the parity flag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when state is IDLE or DONE.
- op  in  1  0 = MUL, 1 = DIV.
- a_data  in  DATA_W  A operand (multiplicand / dividend).
- b_data  in  DATA_W  B operand (multiplier / divisor).
- psw_in  in  8  PSW image captured with the operands.
- busy  out  1  high while iterating (states MUL, DIV).
- done  out  1  one-cycle pulse; results valid this cycle.
- ans_a  out  DATA_W  new A: product low half / quotient.
- ans_b  out  DATA_W  new B: product high half / remainder.
- psw_out  out  8  updated PSW.

Behaviour:
- Reset:
  - Asynchronous, active-high; one clock domain (clk).
  - State -> IDLE; busy = 0, done = 0, ans_a = 0, ans_b = 0, psw_out = 0; iteration counter = 0.
  - Reset mid-operation abandons the operation; no done is issued.
- States: IDLE, MUL, DIV, DONE.
- Accept:
  - In IDLE or DONE with start = 1, the edge captures a_data, b_data, psw_in and op.
  - Next state is MUL (op = 0) or DIV (op = 1, b_data != 0).
  - DIV with b_data == 0 goes directly to DONE.
  - start while busy = 1 is ignored; no queueing.
- MUL: shift-add, one multiplier bit per cycle, DATA_W cycles.
- DIV: restoring division, one quotient bit per cycle, DATA_W cycles.
- Transitions:
  - After the DATA_W-th iteration edge, state -> DONE and results are registered.
  - DONE lasts one cycle with done = 1, then returns to IDLE unless a new start is accepted.
- Latency:
  - start sampled in cycle 0 -> busy in cycles 1..DATA_W, done in cycle DATA_W+1.
  - Divide-by-zero: done in cycle 1, busy never asserted.
- Outputs: ans_a, ans_b and psw_out hold their last values until the next DONE; they do not change while busy.
- MUL result:
  - Full product = a*b, 2*DATA_W bits; ans_a = low half, ans_b = high half.
  - OV = (ans_b != 0).
- DIV result: ans_a = floor(a/b), ans_b = a mod b, OV = 0.
- DIV by zero: ans_a = all ones, ans_b = captured a_data, OV = 1.
- PSW flags:
  - CY = 0 always.
  - P = XOR-reduction of ans_a.
  - All other psw_out bits = captured psw_in.
- Back-to-back: start accepted in the DONE cycle begins a new operation with no idle gap; done still pulses in that DONE cycle.
- Input stability: a_data, b_data, psw_in and op may change freely after the accept edge.

Test Plan:
- MUL, DATA_W=8, a=0x50, b=0xA0, psw_in=0xFF, start in cycle 0 -> done only in cycle 9; ans_a=0x00, ans_b=0x32, psw_out=0x7E (CY=0, OV=1, P=0); busy high exactly in cycles 1..8.
- MUL a=0x0C, b=0x0B, psw_in=0x00 -> ans_a=0x84, ans_b=0x00, psw_out=0x00 (OV=0, P=0).
- DIV a=0xFB, b=0x12, psw_in=0x80 -> ans_a=0x0D, ans_b=0x11, psw_out=0x01 (CY cleared, P=1), done in cycle 9.
- DIV a=0x37, b=0x00 -> done in cycle 1, busy stays 0; ans_a=0xFF, ans_b=0x37, OV=1, CY=0, P=0.
- Handshake:
  - start pulsed in cycle 4 of a MUL is ignored; result unchanged.
  - New start in the DONE cycle yields a second done exactly 9 cycles later.
  - rst asserted in cycle 5 of a DIV -> outputs 0 immediately, no done pulse, IDLE after release.
- DATA_W=16, MUL a=0xFFFF, b=0xFFFF -> done in cycle 17; ans_a=0x0001, ans_b=0xFFFE, OV=1, P=1.
